// File: rtl/gate_mvm_scheduler.sv
// gate_mvm_scheduler: round-robin sharing of one dot-product engine among NGATE LSTM gate requesters
module gate_mvm_scheduler #(
    parameter int NCOL          = 16,
    parameter int DSP48_PER_ROW = 2,
    parameter int NGATE         = 4,
    parameter int MEM_LAT       = 1,
    parameter int MAC_LAT       = 1,
    localparam int COL_W  = $clog2(NCOL),
    localparam int MUX_W  = (DSP48_PER_ROW > 1) ? $clog2(DSP48_PER_ROW) : 1,
    localparam int GATE_W = (NGATE > 1) ? $clog2(NGATE) : 1,
    localparam int AW     = GATE_W + MUX_W + COL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NGATE-1:0]  req,
    input  logic              flush,
    output logic [NGATE-1:0]  grant,
    output logic              busy,
    output logic [AW-1:0]     mem_addr,
    output logic [COL_W-1:0]  x_index,
    output logic              issue_valid,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [MUX_W-1:0]  acc_pass,
    output logic              res_we,
    output logic [GATE_W-1:0] res_gate,
    output logic [NGATE-1:0]  done
);
    localparam int L = MEM_LAT + MAC_LAT;
    localparam int DCNT_W = $clog2(L + 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(NCOL - 1);
    localparam logic [MUX_W-1:0]  PASS_LAST  = MUX_W'(DSP48_PER_ROW - 1);
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(NGATE - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(L - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic [GATE_W-1:0] gate, ptr, pick;
    logic [COL_W-1:0]  col;
    logic [MUX_W-1:0]  pass;
    logic [DCNT_W-1:0] dcnt;
    logic [L-1:0]      en_dly;
    logic [MUX_W-1:0]  pass_dly [L];
    logic issuing, last_issue, stay_issue;

    assign issuing    = state == ISSUE;
    assign last_issue = issuing && col == COL_LAST && pass == PASS_LAST;
    assign stay_issue = issuing && state_nx == ISSUE;

    // Round-robin pick: scanning from the farthest offset down lets the nearest requester at/after ptr win
    always_comb begin
        pick = ptr;
        for (int i = NGATE - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NGATE]) pick = GATE_W'((int'(ptr) + i) % NGATE);
    end

    // Next state; flush aborts any active job straight back to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? ISSUE : IDLE;
            ISSUE:   state_nx = last_issue ? DRAIN : ISSUE;
            DRAIN:   state_nx = (dcnt == DRAIN_LAST) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
        if (flush && state != IDLE) state_nx = IDLE;
    end

    // State, column/pass/drain counters, latched owner and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gate  <= '0;
            ptr   <= '0;
            col   <= '0;
            pass  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == ISSUE) gate <= pick;
            col  <= stay_issue ? col + 1'b1 : '0;
            pass <= !stay_issue ? '0 : (col != COL_LAST) ? pass : (pass == PASS_LAST) ? '0 : pass + 1'b1;
            dcnt <= (state == DRAIN && state_nx == DRAIN) ? dcnt + 1'b1 : '0;
            if (state == DONE && !flush) ptr <= (gate == GATE_LAST) ? '0 : gate + 1'b1;
        end
    end

    // Delay issue strobe and row select by the memory + MAC latency so they meet the product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_dly <= '0;
            for (int i = 0; i < L; i++) pass_dly[i] <= '0;
        end else if (flush) begin
            en_dly <= '0;
            for (int i = 0; i < L; i++) pass_dly[i] <= '0;
        end else begin
            en_dly      <= {en_dly[L-2:0], issuing};
            pass_dly[0] <= issuing ? pass : '0;
            for (int i = 1; i < L; i++) pass_dly[i] <= pass_dly[i-1];
        end
    end

    assign busy        = state != IDLE;
    assign grant       = busy ? NGATE'(1) << gate : '0;
    assign issue_valid = issuing;
    assign mem_addr    = issuing ? {gate, pass, col} : '0;
    assign x_index     = issuing ? col : '0;
    assign acc_clr     = issuing && col == '0 && pass == '0;
    assign acc_en      = en_dly[L-1];
    assign acc_pass    = pass_dly[L-1];
    assign res_we      = state == DONE;
    assign res_gate    = res_we ? gate : '0;
    assign done        = res_we ? grant : '0;
endmodule

// File: tb/tb_gate_mvm_scheduler.sv
// tb_gate_mvm_scheduler: directed scenario tests for the default and a swept-parameter scheduler
module tb_gate_mvm_scheduler;
    logic clk = 0;
    logic reset = 0;
    logic [3:0] req = '0, req_s = '0;
    logic flush = 0, flush_s = 0;
    logic [3:0] grant, done, grant_s, done_s;
    logic busy, issue_valid, acc_clr, acc_en, res_we;
    logic busy_s, issue_valid_s, acc_clr_s, acc_en_s, res_we_s;
    logic [6:0] mem_addr;
    logic [4:0] mem_addr_s;
    logic [3:0] x_index;
    logic [1:0] x_index_s, res_gate, res_gate_s;
    logic [0:0] acc_pass, acc_pass_s;
    int errors = 0, checks = 0, cyc = 0;

    gate_mvm_scheduler d (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .x_index(x_index), .issue_valid(issue_valid), .acc_clr(acc_clr),
        .acc_en(acc_en), .acc_pass(acc_pass), .res_we(res_we), .res_gate(res_gate), .done(done)
    );

    gate_mvm_scheduler #(.NCOL(4), .DSP48_PER_ROW(1), .NGATE(4), .MEM_LAT(2), .MAC_LAT(3)) s (
        .clk(clk), .reset(reset), .req(req_s), .flush(flush_s), .grant(grant_s), .busy(busy_s),
        .mem_addr(mem_addr_s), .x_index(x_index_s), .issue_valid(issue_valid_s), .acc_clr(acc_clr_s),
        .acc_en(acc_en_s), .acc_pass(acc_pass_s), .res_we(res_we_s), .res_gate(res_gate_s), .done(done_s)
    );

    wire [26:0] obs = {grant, busy, issue_valid, mem_addr, x_index, acc_clr, acc_en, acc_pass, res_we, res_gate, done};
    wire [22:0] obs_s = {grant_s, busy_s, issue_valid_s, mem_addr_s, x_index_s, acc_clr_s, acc_en_s, acc_pass_s, res_we_s, res_gate_s, done_s};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            step;
            if (done !== 4'b0000) at = cyc;
        end
    endtask

    task automatic wait_grant(output int at);
        at = -1;
        for (int i = 0; i < 100 && at < 0; i++) begin
            step;
            if (grant !== 4'b0000) at = cyc;
        end
    endtask

    task automatic test_reset;
        step;
        step;
        checks++; if (obs !== 27'd0) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, 27'd0); end
        checks++; if (obs_s !== 23'd0) begin errors++; $display("FAIL reset_outputs_sweep: got %h want %h", obs_s, 23'd0); end
        reset = 1;
        step;
        checks++; if (obs !== 27'd0) begin errors++; $display("FAIL idle_after_reset: got %h want %h", obs, 27'd0); end
    endtask

    task automatic test_single;
        logic [26:0] e;
        int col, pass;
        logic iv;
        req = 4'b0001;
        step;
        for (int c = 1; c <= 36; c++) begin
            col = (c - 1) % 16;
            pass = (c - 1) / 16;
            iv = c <= 32;
            e = {(c <= 35) ? 4'b0001 : 4'b0000, c <= 35, iv,
                 iv ? {2'd0, 1'(pass), 4'(col)} : 7'd0, iv ? 4'(col) : 4'd0,
                 c == 1, (c >= 3 && c <= 34), (c >= 19 && c <= 34), c == 35, 2'd0,
                 (c == 35) ? 4'b0001 : 4'b0000};
            checks++; if (obs !== e) begin errors++; $display("FAIL single c=%0d: got %h want %h", c, obs, e); end
            if (c == 35) req = 4'b0000;
            step;
        end
    endtask

    task automatic test_round_robin;
        int at, prev, rel;
        logic [3:0] eg;
        reset = 0;
        step;
        reset = 1;
        rel = cyc;
        req = 4'b1111;
        prev = rel - 1;
        for (int k = 0; k < 5; k++) begin
            wait_done(at);
            eg = 4'b0001 << (k % 4);
            checks++; if (done !== eg) begin errors++; $display("FAIL rr_done k=%0d: got %b want %b", k, done, eg); end
            checks++; if (res_gate !== 2'(k % 4) || grant !== eg || res_we !== 1'b1) begin errors++; $display("FAIL rr_res k=%0d: got gate %0d grant %b we %b want gate %0d grant %b we 1", k, res_gate, grant, res_we, k % 4, eg); end
            checks++; if (at - prev !== ((k == 0) ? 36 : 36)) begin errors++; $display("FAIL rr_spacing k=%0d: got %0d want 36", k, at - prev); end
            prev = at;
            if (k == 4) req = 4'b0000;
        end
    endtask

    task automatic test_contention;
        int at;
        req = 4'b1000;
        wait_done(at);
        checks++; if (done !== 4'b1000 || res_gate !== 2'd3) begin errors++; $display("FAIL cont_first: got %b/%0d want 1000/3", done, res_gate); end
        req = 4'b1001;
        wait_done(at);
        checks++; if (done !== 4'b0001 || res_gate !== 2'd0) begin errors++; $display("FAIL cont_wrap: got %b/%0d want 0001/0", done, res_gate); end
        wait_done(at);
        checks++; if (done !== 4'b1000 || res_gate !== 2'd3) begin errors++; $display("FAIL cont_held: got %b/%0d want 1000/3", done, res_gate); end
        req = 4'b0000;
    endtask

    task automatic test_flush;
        int at, g;
        req = 4'b0100;
        wait_grant(g);
        checks++; if ({grant, acc_clr, mem_addr} !== {4'b0100, 1'b1, 7'b1000000}) begin errors++; $display("FAIL flush_grant: got %b %b %b want 0100 1 1000000", grant, acc_clr, mem_addr); end
        for (int i = 0; i < 10; i++) step;
        checks++; if (mem_addr !== 7'b1001010 || x_index !== 4'd10) begin errors++; $display("FAIL flush_col10: got %b/%0d want 1001010/10", mem_addr, x_index); end
        flush = 1;
        req = 4'b1100;
        step;
        flush = 0;
        checks++; if ({grant, busy, issue_valid, acc_en, res_we, done} !== 11'd0) begin errors++; $display("FAIL flush_idle: got %b %b %b %b %b %b want all 0", grant, busy, issue_valid, acc_en, res_we, done); end
        step;
        g = cyc;
        checks++; if ({grant, acc_clr, mem_addr} !== {4'b0100, 1'b1, 7'b1000000}) begin errors++; $display("FAIL flush_restart: got %b %b %b want 0100 1 1000000", grant, acc_clr, mem_addr); end
        req = 4'b0000;
        wait_done(at);
        checks++; if (done !== 4'b0100 || at - g !== 34) begin errors++; $display("FAIL flush_done: got %b after %0d want 0100 after 34", done, at - g); end
    endtask

    task automatic test_reset_mid;
        int at, g, rel;
        req = 4'b0010;
        wait_grant(g);
        for (int i = 0; i < 19; i++) step;
        #2;
        reset = 0;
        #1;
        checks++; if (obs !== 27'd0) begin errors++; $display("FAIL midreset_async: got %h want %h", obs, 27'd0); end
        step;
        checks++; if (obs !== 27'd0) begin errors++; $display("FAIL midreset_held: got %h want %h", obs, 27'd0); end
        reset = 1;
        rel = cyc;
        step;
        checks++; if ({grant, acc_clr, issue_valid, mem_addr} !== {4'b0010, 1'b1, 1'b1, 7'b0100000}) begin errors++; $display("FAIL midreset_regrant: got %b %b %b %b want 0010 1 1 0100000", grant, acc_clr, issue_valid, mem_addr); end
        wait_done(at);
        checks++; if (done !== 4'b0010 || at - rel !== 35) begin errors++; $display("FAIL midreset_done: got %b after %0d want 0010 after 35", done, at - rel); end
        req = 4'b0000;
    endtask

    task automatic test_sweep;
        logic [22:0] e;
        logic iv;
        req_s = 4'b0001;
        step;
        for (int c = 1; c <= 11; c++) begin
            iv = c <= 4;
            e = {(c <= 10) ? 4'b0001 : 4'b0000, c <= 10, iv,
                 iv ? {2'd0, 1'b0, 2'(c - 1)} : 5'd0, iv ? 2'(c - 1) : 2'd0,
                 c == 1, (c >= 6 && c <= 9), 1'b0, c == 10, 2'd0,
                 (c == 10) ? 4'b0001 : 4'b0000};
            checks++; if (obs_s !== e) begin errors++; $display("FAIL sweep c=%0d: got %h want %h", c, obs_s, e); end
            if (c == 10) req_s = 4'b0000;
            step;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_contention;
        test_flush;
        test_reset_mid;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
